// File: rtl/exc_ctrl.sv
// Exception sequencer: detects trap/eret in decode, requests CP0, then redirects the PC.
module exc_ctrl #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_instr_valid,
  input  logic               i_op_syscall,
  input  logic               i_op_break,
  input  logic               i_op_teq,
  input  logic               i_op_eret,
  input  logic               i_teq_eq,
  input  logic               i_op_mfc0,
  input  logic               i_op_mtc0,
  input  logic [4:0]         i_rd_in,
  input  logic [31:0]        i_pc,
  input  logic [31:0]        i_status,
  input  logic [31:0]        i_exc_addr,
  output logic               o_cp0_exception,
  output logic               o_cp0_eret,
  output logic [4:0]         o_cp0_cause,
  output logic [31:0]        o_cp0_pc,
  output logic               o_cp0_mfc0,
  output logic               o_cp0_mtc0,
  output logic [4:0]         o_cp0_rd,
  output logic               o_stall,
  output logic               o_pc_load,
  output logic [31:0]        o_pc_target,
  output logic               o_busy,
  output logic [COUNT_W-1:0] o_exc_count,
  output logic [2:0]         o_handler_depth
);

  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned DEPTH_W = 3;
  localparam logic [CAUSE_W-1:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [CAUSE_W-1:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [CAUSE_W-1:0] CAUSE_TEQ     = 5'b01101;
  localparam logic [CAUSE_W-1:0] CAUSE_ERET    = 5'b00000;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX     = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_REDIR} state_e;
  typedef enum logic [1:0] {K_SYSCALL, K_BREAK, K_TEQ, K_ERET} kind_e;

  state_e               r_state;
  state_e               w_next;
  kind_e                r_kind;
  kind_e                w_kind;
  logic [CAUSE_W-1:0]   w_cause;
  logic                 w_detect;
  logic                 w_taken;
  logic                 w_idle;
  logic                 w_unused;

  logic                 r_cp0_exception;
  logic                 r_cp0_eret;
  logic [CAUSE_W-1:0]   r_cp0_cause;
  logic [31:0]          r_cp0_pc;
  logic                 r_pc_load;
  logic [31:0]          r_pc_target;
  logic                 r_busy;
  logic [COUNT_W-1:0]   r_exc_count;
  logic [DEPTH_W-1:0]   r_handler_depth;

  // Only the three enable bits of status matter here.
  assign w_unused = ^{i_status[31:4], i_status[0]};

  // Trap detection and priority encode (eret > syscall > break > teq).
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_detect = w_idle & i_instr_valid &
               (i_op_eret | i_op_syscall | i_op_break | (i_op_teq & i_teq_eq));
    w_kind   = K_TEQ;
    w_cause  = CAUSE_TEQ;
    if (i_op_eret) begin
      w_kind  = K_ERET;
      w_cause = CAUSE_ERET;
    end else if (i_op_syscall) begin
      w_kind  = K_SYSCALL;
      w_cause = CAUSE_SYSCALL;
    end else if (i_op_break) begin
      w_kind  = K_BREAK;
      w_cause = CAUSE_BREAK;
    end
  end

  // Status enable bit for the latched trap kind; eret is never counted as taken.
  always_comb begin
    w_taken = 1'b0;
    case (r_kind)
      K_SYSCALL: w_taken = i_status[1];
      K_BREAK:   w_taken = i_status[2];
      K_TEQ:     w_taken = i_status[3];
      default:   w_taken = 1'b0;
    endcase
  end

  // Next-state and combinational pipeline controls.
  always_comb begin
    w_next     = r_state;
    o_stall    = w_detect | ~w_idle;
    o_cp0_mtc0 = i_instr_valid & i_op_mtc0 & w_idle & ~w_detect;
    o_cp0_mfc0 = i_instr_valid & i_op_mfc0 & w_idle & ~w_detect;
    o_cp0_rd   = i_rd_in;
    case (r_state)
      S_IDLE:  if (w_detect) w_next = S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  w_next = S_REDIR;
      S_REDIR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request/redirect outputs, latched at detect so they are valid for the REQ cycle only.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cp0_exception <= 1'b0;
      r_cp0_eret      <= 1'b0;
      r_cp0_cause     <= '0;
      r_cp0_pc        <= '0;
      r_kind          <= K_SYSCALL;
      r_pc_target     <= '0;
      r_pc_load       <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_cp0_exception <= (w_next == S_REQ);
      r_cp0_eret      <= (w_next == S_REQ) && (w_kind == K_ERET);
      r_cp0_cause     <= (w_next == S_REQ) ? w_cause : '0;
      r_cp0_pc        <= (w_next == S_REQ) ? i_pc : '0;
      if (w_next == S_REQ) r_kind <= w_kind;
      if (r_state == S_WAIT) r_pc_target <= i_exc_addr;
      r_pc_load       <= (w_next == S_REDIR);
      r_busy          <= (w_next != S_IDLE);
    end
  end

  // Taken-exception count and handler nesting depth, both saturating.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_exc_count     <= '0;
      r_handler_depth <= '0;
    end else if (r_state == S_REQ) begin
      if (r_kind == K_ERET) begin
        if (r_handler_depth != '0) r_handler_depth <= r_handler_depth - DEPTH_W'(1);
      end else if (w_taken) begin
        if (r_exc_count != '1) r_exc_count <= r_exc_count + COUNT_W'(1);
        if (r_handler_depth != DEPTH_MAX) r_handler_depth <= r_handler_depth + DEPTH_W'(1);
      end
    end
  end

  assign o_cp0_exception = r_cp0_exception;
  assign o_cp0_eret      = r_cp0_eret;
  assign o_cp0_cause     = r_cp0_cause;
  assign o_cp0_pc        = r_cp0_pc;
  assign o_pc_load       = r_pc_load;
  assign o_pc_target     = r_pc_target;
  assign o_busy          = r_busy;
  assign o_exc_count     = r_exc_count;
  assign o_handler_depth = r_handler_depth;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl with a small behavioural CP0 and a redirect scoreboard.
module tb_exc_ctrl;
  localparam int unsigned COUNT_W = 16;
  localparam logic [31:0] HANDLER = 32'h0040_0004;

  logic clk = 1'b0;
  logic rst_n;
  logic instr_valid, op_syscall, op_break, op_teq, op_eret, teq_eq, op_mfc0, op_mtc0;
  logic [4:0] rd_in;
  logic [31:0] pc, status, exc_addr;
  logic cp0_exception, cp0_eret, cp0_mfc0, cp0_mtc0, stall, pc_load, busy;
  logic [4:0] cp0_cause, cp0_rd;
  logic [31:0] cp0_pc, pc_target;
  logic [COUNT_W-1:0] exc_count;
  logic [2:0] handler_depth;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_t;
  logic [31:0] cp0_epc;

  exc_ctrl #(.COUNT_W(COUNT_W)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_instr_valid(instr_valid),
    .i_op_syscall(op_syscall), .i_op_break(op_break), .i_op_teq(op_teq),
    .i_op_eret(op_eret), .i_teq_eq(teq_eq), .i_op_mfc0(op_mfc0), .i_op_mtc0(op_mtc0),
    .i_rd_in(rd_in), .i_pc(pc), .i_status(status), .i_exc_addr(exc_addr),
    .o_cp0_exception(cp0_exception), .o_cp0_eret(cp0_eret), .o_cp0_cause(cp0_cause),
    .o_cp0_pc(cp0_pc), .o_cp0_mfc0(cp0_mfc0), .o_cp0_mtc0(cp0_mtc0), .o_cp0_rd(cp0_rd),
    .o_stall(stall), .o_pc_load(pc_load), .o_pc_target(pc_target), .o_busy(busy),
    .o_exc_count(exc_count), .o_handler_depth(handler_depth)
  );

  always #5 clk = ~clk;

  // CP0 model: on a request, save EPC for taken traps and publish the redirect address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_addr <= '0;
      cp0_epc  <= '0;
    end else if (cp0_exception) begin
      if (cp0_eret) exc_addr <= cp0_epc;
      else if ((cp0_cause == 5'b01000 && status[1]) || (cp0_cause == 5'b01001 && status[2]) ||
               (cp0_cause == 5'b01101 && status[3])) begin
        cp0_epc  <= cp0_pc;
        exc_addr <= HANDLER;
      end else exc_addr <= cp0_pc + 32'd4;
    end
  end

  // Scoreboard: every pc_load must match the oldest expected redirect target.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pc_load === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pc_load: pc_load=1 with nothing pending, pc_target=%h", pc_target);
      end else begin
        exp_t = exp_q.pop_front();
        if (pc_target !== exp_t) begin
          errors++;
          $display("FAIL pc_target: got %h expected %h", pc_target, exp_t);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    instr_valid = 0; op_syscall = 0; op_break = 0; op_teq = 0; op_eret = 0;
    teq_eq = 0; op_mfc0 = 0; op_mtc0 = 0; rd_in = '0; pc = '0;
  endtask

  // Drive one trap at T0 (held through T3) and check the T0..T3 sequence.
  task automatic do_trap(input string name, input logic sys, input logic brk, input logic teq,
                         input logic eret, input logic mtc0, input logic [31:0] pc_v,
                         input logic [31:0] st, input logic [31:0] exp_tgt,
                         input logic [4:0] exp_cause, input logic [COUNT_W-1:0] exp_cnt,
                         input logic [2:0] exp_dep);
    @(negedge clk);
    instr_valid = 1; op_syscall = sys; op_break = brk; op_teq = teq; teq_eq = teq;
    op_eret = eret; op_mtc0 = mtc0; rd_in = 5'd12; pc = pc_v; status = st;
    exp_q.push_back(exp_tgt);
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0 || cp0_exception !== 1'b0 || cp0_mtc0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_t0: stall=%b busy=%b exc=%b mtc0=%b expected 1 0 0 0", name, stall, busy, cp0_exception, cp0_mtc0);
    end
    @(negedge clk); #1;
    checks++;
    if (cp0_exception !== 1'b1 || cp0_eret !== eret || cp0_cause !== exp_cause || cp0_pc !== pc_v) begin
      errors++;
      $display("FAIL %s_t1_req: exc=%b eret=%b cause=%b pc=%h expected 1 %b %b %h", name, cp0_exception, cp0_eret, cp0_cause, cp0_pc, eret, exp_cause, pc_v);
    end
    checks++;
    if (stall !== 1'b1 || busy !== 1'b1 || cp0_mtc0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_t1_ctl: stall=%b busy=%b mtc0=%b expected 1 1 0", name, stall, busy, cp0_mtc0);
    end
    @(negedge clk); #1;
    checks++;
    if (cp0_exception !== 1'b0 || cp0_cause !== 5'd0 || cp0_pc !== 32'd0 || stall !== 1'b1 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL %s_t2: exc=%b cause=%b pc=%h stall=%b pc_load=%b expected 0 0 0 1 0", name, cp0_exception, cp0_cause, cp0_pc, stall, pc_load);
    end
    checks++;
    if (exc_count !== exp_cnt || handler_depth !== exp_dep) begin
      errors++;
      $display("FAIL %s_counters: exc_count=%0d depth=%0d expected %0d %0d", name, exc_count, handler_depth, exp_cnt, exp_dep);
    end
    @(negedge clk); #1;
    checks++;
    if (pc_load !== 1'b1 || stall !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_t3: pc_load=%b stall=%b busy=%b expected 1 1 1", name, pc_load, stall, busy);
    end
    idle_inputs();
  endtask

  task automatic check_idle(input string name);
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0 || cp0_exception !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: stall=%b busy=%b pc_load=%b exc=%b expected all 0", name, stall, busy, pc_load, cp0_exception);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; status = '0; idle_inputs();
    #2;
    checks++;
    if ({cp0_exception, cp0_eret, cp0_cause, cp0_pc, pc_load, pc_target, busy, exc_count, handler_depth, stall} !== '0) begin
      errors++;
      $display("FAIL reset_state: exc=%b eret=%b cause=%b pc=%h load=%b tgt=%h busy=%b cnt=%0d dep=%0d stall=%b expected all 0",
               cp0_exception, cp0_eret, cp0_cause, cp0_pc, pc_load, pc_target, busy, exc_count, handler_depth, stall);
    end
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  task automatic test_syscall_eret_break();
    do_trap("syscall", 1, 0, 0, 0, 0, 32'h0040_0100, 32'h0000_000F, HANDLER, 5'b01000, 1, 1);
    check_idle("syscall");
    do_trap("eret", 0, 0, 0, 1, 0, 32'h0040_0110, 32'h0000_000F, 32'h0040_0100, 5'b00000, 1, 0);
    check_idle("eret");
    do_trap("break_masked", 0, 1, 0, 0, 0, 32'h0040_0200, 32'h0000_000B, 32'h0040_0204, 5'b01001, 1, 0);
    check_idle("break_masked");
  endtask

  task automatic test_teq();
    @(negedge clk);
    instr_valid = 1; op_teq = 1; teq_eq = 0; pc = 32'h0040_0300; status = 32'h0000_000F;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL teq_ne_stall: stall=%b expected 0", stall);
    end
    @(negedge clk); idle_inputs(); #1;
    checks++;
    if (cp0_exception !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL teq_ne_req: exc=%b busy=%b expected 0 0", cp0_exception, busy);
    end
    do_trap("teq_eq", 0, 0, 1, 0, 0, 32'h0040_0300, 32'h0000_000F, HANDLER, 5'b01101, 2, 1);
    check_idle("teq_eq");
  endtask

  task automatic test_cp0_moves();
    @(negedge clk);
    instr_valid = 1; op_mtc0 = 1; rd_in = 5'd12;
    #1;
    checks++;
    if (cp0_mtc0 !== 1'b1 || cp0_mfc0 !== 1'b0 || cp0_rd !== 5'd12 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mtc0: mtc0=%b mfc0=%b rd=%0d stall=%b expected 1 0 12 0", cp0_mtc0, cp0_mfc0, cp0_rd, stall);
    end
    op_mtc0 = 0; op_mfc0 = 1; rd_in = 5'd5;
    #1;
    checks++;
    if (cp0_mfc0 !== 1'b1 || cp0_mtc0 !== 1'b0 || cp0_rd !== 5'd5) begin
      errors++;
      $display("FAIL mfc0: mfc0=%b mtc0=%b rd=%0d expected 1 0 5", cp0_mfc0, cp0_mtc0, cp0_rd);
    end
    instr_valid = 0;
    #1;
    checks++;
    if (cp0_mfc0 !== 1'b0) begin
      errors++;
      $display("FAIL mfc0_invalid: mfc0=%b expected 0", cp0_mfc0);
    end
    idle_inputs();
    check_idle("cp0_moves");
    do_trap("mtc0_syscall", 1, 0, 0, 0, 1, 32'h0040_0400, 32'h0000_000F, HANDLER, 5'b01000, 3, 2);
    check_idle("mtc0_syscall");
  endtask

  task automatic test_priority();
    do_trap("prio_eret_sys", 1, 0, 0, 1, 0, 32'h0040_0410, 32'h0000_000F, 32'h0040_0400, 5'b00000, 3, 1);
    do_trap("prio_sys_brk", 1, 1, 0, 0, 0, 32'h0040_0500, 32'h0000_0002, HANDLER, 5'b01000, 4, 2);
    do_trap("prio_brk_teq", 0, 1, 1, 0, 0, 32'h0040_0600, 32'h0000_000F, HANDLER, 5'b01001, 5, 3);
    check_idle("priority");
  endtask

  task automatic test_back_to_back();
    do_trap("b2b_a", 1, 0, 0, 0, 0, 32'h0040_0700, 32'h0000_000F, HANDLER, 5'b01000, 6, 4);
    do_trap("b2b_b", 0, 1, 0, 0, 0, 32'h0040_0800, 32'h0000_000F, HANDLER, 5'b01001, 7, 5);
    do_trap("depth_6", 1, 0, 0, 0, 0, 32'h0040_0900, 32'h0000_000F, HANDLER, 5'b01000, 8, 6);
    do_trap("depth_7", 1, 0, 0, 0, 0, 32'h0040_0A00, 32'h0000_000F, HANDLER, 5'b01000, 9, 7);
    do_trap("depth_sat", 1, 0, 0, 0, 0, 32'h0040_0B00, 32'h0000_000F, HANDLER, 5'b01000, 10, 7);
    check_idle("back_to_back");
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    instr_valid = 1; op_syscall = 1; pc = 32'h0040_0E00; status = 32'h0000_000F;
    @(negedge clk); idle_inputs();
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || exc_count !== 16'd11) begin
      errors++;
      $display("FAIL rst_wait_pre: busy=%b exc_count=%0d expected 1 11", busy, exc_count);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({cp0_exception, cp0_eret, cp0_cause, cp0_pc, pc_load, pc_target, busy, exc_count, handler_depth, stall} !== '0) begin
      errors++;
      $display("FAIL rst_wait_clear: exc=%b cause=%b pc=%h load=%b tgt=%h busy=%b cnt=%0d dep=%0d stall=%b expected all 0",
               cp0_exception, cp0_cause, cp0_pc, pc_load, pc_target, busy, exc_count, handler_depth, stall);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (pc_load !== 1'b0 || busy !== 1'b0 || exc_count !== '0 || handler_depth !== 3'd0) begin
        errors++;
        $display("FAIL rst_wait_after: cycle %0d pc_load=%b busy=%b cnt=%0d dep=%0d expected 0 0 0 0", i, pc_load, busy, exc_count, handler_depth);
      end
    end
    do_trap("eret_depth0", 0, 0, 0, 1, 0, 32'h0040_0C00, 32'h0000_000F, 32'h0000_0000, 5'b00000, 0, 0);
    do_trap("sys_masked", 1, 0, 0, 0, 0, 32'h0040_0D00, 32'h0000_0000, 32'h0040_0D04, 5'b01000, 0, 0);
    check_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_syscall_eret_break();
    test_teq();
    test_cp0_moves();
    test_priority();
    test_back_to_back();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pc_load: %0d redirects pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
